// File: rtl/timekeeper_pkg.sv
// timekeeper_pkg: shared mode encoding, field widths and binary-to-BCD helper for the timekeeper.
package timekeeper_pkg;
  localparam int FIELD_W = 7;
  localparam int BCD_W = 8;
  typedef enum logic [1:0] {
    MODE_RUN    = 2'd0,
    MODE_PAUSED = 2'd1,
    MODE_ADJUST = 2'd2
  } mode_e;
  function automatic logic [BCD_W-1:0] bin_to_bcd(input logic [FIELD_W-1:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 7'd10);
    ones = 4'(v % 7'd10);
    return {tens, ones};
  endfunction
endpackage

// File: rtl/timekeeper_counter_tick_divider.sv
// tick_divider: free-running modulo-DIV counter emitting a one-cycle tick on its last count.
module tick_divider #(
  parameter int DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    tick = enable && (cnt_q == LAST);
    cnt_d = (clear || tick) ? '0 : enable ? cnt_q + CW'(1) : cnt_q;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/timekeeper_counter.sv
// timekeeper_counter: minutes/seconds core with pause, per-field adjust, rollover pulse and BCD/blink outputs.
module timekeeper_counter
  import timekeeper_pkg::*;
#(
  parameter int BASE_CLK   = 100_000_000,
  parameter int RUN_FREQ   = 1,
  parameter int ADJ_FREQ   = 2,
  parameter int BLINK_FREQ = 4,
  parameter int SEC_MAX    = 59,
  parameter int MIN_MAX    = 59
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               ADJ,
  input  logic               SEL,
  input  logic               PAUSE,
  output logic [FIELD_W-1:0] MINUTES,
  output logic [FIELD_W-1:0] SECONDS,
  output logic [BCD_W-1:0]   MIN_BCD,
  output logic [BCD_W-1:0]   SEC_BCD,
  output logic               BLINK_EN,
  output logic               WRAP,
  output logic [1:0]         MODE
);
  localparam int RUN_DIV   = BASE_CLK / RUN_FREQ;
  localparam int ADJ_DIV   = BASE_CLK / ADJ_FREQ;
  localparam int BLINK_DIV = BASE_CLK / BLINK_FREQ;
  localparam logic [FIELD_W-1:0] SEC_LIM = FIELD_W'(SEC_MAX);
  localparam logic [FIELD_W-1:0] MIN_LIM = FIELD_W'(MIN_MAX);

  if ((BASE_CLK % RUN_FREQ) != 0 || (BASE_CLK % ADJ_FREQ) != 0 || (BASE_CLK % BLINK_FREQ) != 0 ||
      RUN_DIV < 2 || ADJ_DIV < 2 || BLINK_DIV < 2 ||
      SEC_MAX < 1 || SEC_MAX > 99 || MIN_MAX < 1 || MIN_MAX > 99) begin : g_bad_params
    $error("timekeeper_counter: divisors must be integers >= 2 and field limits 1..99");
  end

  mode_e              mode_q, mode_d;
  logic               paused_q, paused_d;
  logic               phase_q, phase_d;
  logic               wrap_q, wrap_d;
  logic [FIELD_W-1:0] sec_q, sec_d, min_q, min_d;
  logic [FIELD_W-1:0] sec_inc, min_inc;
  logic               in_run, in_adj, run_step, adj_step, sec_end;
  logic               run_tick, adj_tick, blink_tick;

  tick_divider #(.DIV(RUN_DIV)) u_run_div (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .enable(in_run), .clear(1'b0), .tick(run_tick)
  );
  tick_divider #(.DIV(ADJ_DIV)) u_adj_div (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .enable(in_adj), .clear(!in_adj), .tick(adj_tick)
  );
  tick_divider #(.DIV(BLINK_DIV)) u_blink_div (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .enable(in_adj), .clear(!in_adj), .tick(blink_tick)
  );

  always_comb begin
    in_run   = mode_q == MODE_RUN;
    in_adj   = mode_q == MODE_ADJUST;
    paused_d = paused_q ^ (PAUSE && !ADJ);
    mode_d   = ADJ ? MODE_ADJUST : paused_d ? MODE_PAUSED : MODE_RUN;
    sec_end  = sec_q == SEC_LIM;
    sec_inc  = sec_end ? '0 : sec_q + FIELD_W'(1);
    min_inc  = (min_q == MIN_LIM) ? '0 : min_q + FIELD_W'(1);
    run_step = in_run && run_tick;
    adj_step = in_adj && adj_tick;
    // Run mode carries seconds into minutes; adjust mode wraps each field on its own.
    sec_d    = (run_step || (adj_step && SEL)) ? sec_inc : sec_q;
    min_d    = ((run_step && sec_end) || (adj_step && !SEL)) ? min_inc : min_q;
    wrap_d   = run_step && sec_end && (min_q == MIN_LIM);
    phase_d  = !in_adj ? 1'b1 : blink_tick ? !phase_q : phase_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_q   <= MODE_RUN;
      paused_q <= 1'b0;
      phase_q  <= 1'b1;
      wrap_q   <= 1'b0;
      sec_q    <= '0;
      min_q    <= '0;
    end else begin
      mode_q   <= mode_d;
      paused_q <= paused_d;
      phase_q  <= phase_d;
      wrap_q   <= wrap_d;
      sec_q    <= sec_d;
      min_q    <= min_d;
    end
  end

  assign MINUTES  = min_q;
  assign SECONDS  = sec_q;
  assign MIN_BCD  = bin_to_bcd(min_q);
  assign SEC_BCD  = bin_to_bcd(sec_q);
  assign BLINK_EN = in_adj ? phase_q : 1'b1;
  assign WRAP     = wrap_q;
  assign MODE     = mode_q;
endmodule
